// File: rtl/prod_accum_if.sv
// Handshake bundle between the product source, prod_accum and the result consumer.
// The slave modport is the accumulator's view; the master modport drives it.
interface prod_accum_if #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [15:0]       out_cnt;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

// File: rtl/prod_accum.sv
// Frame accumulator for unsigned products: sums up to LEN products (or until in_last)
// and holds one result per frame. Define PROD_ACCUM_SAT_EN for a saturating accumulator.
module prod_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN    = 16
) (
    input  logic           clk,
    input  logic           rst,
    prod_accum_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_int;
    logic               in_xfer;
    logic [ACC_W:0]     sum;
    logic [16:0]        cnt_inc;

    function automatic logic [ACC_W-1:0] zext(input logic [PROD_W-1:0] p);
        logic [ACC_W-1:0] r;
        r = '0;
        r[PROD_W-1:0] = p;
        return r;
    endfunction

    // Top bit of the result is the overflow flag for this add.
    function automatic logic [ACC_W:0] add_acc(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, zext(p)};
`ifdef PROD_ACCUM_SAT_EN
        if (s[ACC_W] || (&a))
            s = {1'b1, {ACC_W{1'b1}}};
`endif
        return s;
    endfunction

    assign in_ready_int  = (state_q != DONE) && !rst;
    assign in_xfer       = bus.in_valid && in_ready_int;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum     = add_acc(acc_q, bus.in_prod);
        cnt_inc = {1'b0, cnt_q} + 17'd1;
        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    acc_d = zext(bus.in_prod);
                    cnt_d = 16'd1;
                    ovf_d = 1'b0;
                    if (LEN == 1 || bus.in_last)
                        state_d = DONE;
                    else
                        state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    acc_d = sum[ACC_W-1:0];
                    cnt_d = cnt_inc[15:0];
                    ovf_d = ovf_q | sum[ACC_W];
                    if (cnt_inc == 17'(LEN) || bus.in_last)
                        state_d = DONE;
                end
            end
            DONE: begin
                // Result is held until the consumer takes it, then the frame state is cleared.
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: three instances (LEN=4/ACC_W=40, LEN=3/ACC_W=40,
// LEN=4/ACC_W=33); expected frame results are queued by stimulus and popped by a monitor.
module tb_prod_accum;
    typedef struct packed {
        logic [39:0] acc;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic        il   [3];
    logic        ordy [3];
    logic [31:0] ip   [3];
    logic        ird  [3];
    logic        ov   [3];
    logic        ovf  [3];
    logic [15:0] oc   [3];
    logic [39:0] oa   [3];

    prod_accum_if #(.PROD_W(32), .ACC_W(40)) if0 ();
    prod_accum_if #(.PROD_W(32), .ACC_W(40)) if1 ();
    prod_accum_if #(.PROD_W(32), .ACC_W(33)) if2 ();

    prod_accum #(.PROD_W(32), .ACC_W(40), .LEN(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    prod_accum #(.PROD_W(32), .ACC_W(40), .LEN(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    prod_accum #(.PROD_W(32), .ACC_W(33), .LEN(4)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    assign if0.in_valid = iv[0];  assign if0.in_prod = ip[0];  assign if0.in_last = il[0];  assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];  assign if1.in_prod = ip[1];  assign if1.in_last = il[1];  assign if1.out_ready = ordy[1];
    assign if2.in_valid = iv[2];  assign if2.in_prod = ip[2];  assign if2.in_last = il[2];  assign if2.out_ready = ordy[2];
    assign ird[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign oa[0] = if0.out_acc;          assign oc[0] = if0.out_cnt; assign ovf[0] = if0.out_ovf;
    assign ird[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign oa[1] = if1.out_acc;          assign oc[1] = if1.out_cnt; assign ovf[1] = if1.out_ovf;
    assign ird[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign oa[2] = {7'b0, if2.out_acc}; assign oc[2] = if2.out_cnt; assign ovf[2] = if2.out_ovf;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [39:0] a, input logic [15:0] c, input logic o);
        exp_t e;
        e.acc = a; e.cnt = c; e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Present one product and return #1 after the edge on which it was accepted.
    task automatic send(input int d, input logic [31:0] p, input logic last);
        bit done;
        done = 0;
        iv[d] = 1'b1; ip[d] = p; il[d] = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ird[d]) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: dut%0d in_ready stayed %0b, expected 1", d, ird[d]);
        end
        iv[d] = 1'b0; il[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 50) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every output transfer on any instance consumes one expected result.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ov[g] && ordy[g] && !rst) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: dut%0d acc=%0h cnt=%0d, expected no result", g, oa[g], oc[g]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_acc", 64'(oa[g]), 64'(e.acc));
                    chk("out_cnt", 64'(oc[g]), 64'(e.cnt));
                    chk("out_ovf", 64'(ovf[g]), 64'(e.ovf));
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; il[g] = 1'b0; ip[g] = '0; ordy[g] = 1'b1;
        end
        rst = 1'b1;
        idle(2);
        chk("rst_in_ready0", 64'(ird[0]), 64'd0);
        chk("rst_in_ready2", 64'(ird[2]), 64'd0);
        rst = 1'b0;
        idle(1);
        chk("post_rst_in_ready", 64'(ird[0]), 64'd1);
        chk("post_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("post_rst_out_acc", 64'(oa[0]), 64'd0);
        chk("post_rst_out_cnt", 64'(oc[0]), 64'd0);
        chk("post_rst_out_ovf", 64'(ovf[0]), 64'd0);

        // 1,2,3,4 back-to-back; one non-accepting cycle while the result is shown
        push_exp(40'd10, 16'd4, 1'b0);
        send(0, 32'd1, 1'b0); send(0, 32'd2, 1'b0); send(0, 32'd3, 1'b0); send(0, 32'd4, 1'b0);
        chk("t1_out_valid", 64'(ov[0]), 64'd1);
        chk("t1_in_ready_done", 64'(ird[0]), 64'd0);
        idle(1);
        chk("t1_in_ready_after", 64'(ird[0]), 64'd1);
        chk("t1_out_valid_after", 64'(ov[0]), 64'd0);
        chk("t1_acc_cleared", 64'(oa[0]), 64'd0);

        // early close with in_last, then a fresh frame
        push_exp(40'd300, 16'd2, 1'b0);
        send(0, 32'd100, 1'b0); send(0, 32'd200, 1'b1);
        idle(2);
        push_exp(40'd7, 16'd1, 1'b0);
        send(0, 32'd7, 1'b1);
        drain();

        // in_last coinciding with the LEN-th product is a single frame end
        push_exp(40'd10, 16'd4, 1'b0);
        send(0, 32'd1, 1'b0); send(0, 32'd2, 1'b0); send(0, 32'd3, 1'b0); send(0, 32'd4, 1'b1);
        push_exp(40'd5, 16'd1, 1'b0);
        send(0, 32'd5, 1'b1);
        drain();

        // output backpressure with upstream still presenting a product
        ordy[0] = 1'b0;
        push_exp(40'd20, 16'd4, 1'b0);
        send(0, 32'd5, 1'b0); send(0, 32'd5, 1'b0); send(0, 32'd5, 1'b0); send(0, 32'd5, 1'b0);
        iv[0] = 1'b1; ip[0] = 32'd99;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(ov[0]), 64'd1);
            chk("t3_hold_acc", 64'(oa[0]), 64'd20);
            chk("t3_hold_cnt", 64'(oc[0]), 64'd4);
            chk("t3_hold_in_ready", 64'(ird[0]), 64'd0);
            idle(1);
        end
        ordy[0] = 1'b1;
        push_exp(40'd99, 16'd1, 1'b0);
        send(0, 32'd99, 1'b1);
        drain();

        // carry-out at ACC_W=33
`ifdef PROD_ACCUM_SAT_EN
        push_exp(40'h1FFFFFFFF, 16'd4, 1'b1);
`else
        push_exp(40'h1FFFFFFFC, 16'd4, 1'b1);
`endif
        for (int i = 0; i < 4; i++) send(2, 32'hFFFFFFFF, 1'b0);
        drain();

        // reset in the middle of a frame discards it
        send(0, 32'd7, 1'b0); send(0, 32'd9, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_in_ready_in_rst", 64'(ird[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_in_ready_after_rst", 64'(ird[0]), 64'd1);
        chk("t5_acc_after_rst", 64'(oa[0]), 64'd0);
        chk("t5_cnt_after_rst", 64'(oc[0]), 64'd0);
        chk("t5_valid_after_rst", 64'(ov[0]), 64'd0);
        push_exp(40'd4, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 32'd1, 1'b0);
        drain();

        // bubbles inside a frame on the LEN=3 instance
        push_exp(40'd60, 16'd3, 1'b0);
        send(1, 32'd10, 1'b0); idle(2);
        send(1, 32'd20, 1'b0); idle(2);
        chk("t6_no_early_valid", 64'(ov[1]), 64'd0);
        send(1, 32'd30, 1'b0);
        chk("t6_valid", 64'(ov[1]), 64'd1);
        drain();

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
